// File: rtl/debug_loader_unit_pkg.sv
// Shared types and default command codes for the UART debug/program loader.
// Imported by the loader top and its word serializer.
package debug_loader_unit_pkg;

  localparam logic [7:0] CMD_STEP_DEF = 8'h0F;
  localparam logic [7:0] CMD_CONT_DEF = 8'hF0;
  localparam int         ADDR_W_DEF   = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_WORD  = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WAIT_CMD = 3'd3,
    ST_STEP     = 3'd4,
    ST_RUN      = 3'd5,
    ST_REPORT   = 3'd6,
    ST_DONE     = 3'd7
  } dl_state_e;

  // Per-word sequencing inside REPORT: address the regfile, let it settle, load, drain.
  typedef enum logic [1:0] {
    RP_ADDR   = 2'd0,
    RP_SETTLE = 2'd1,
    RP_LOAD   = 2'd2,
    RP_BUSY   = 2'd3
  } rpt_phase_e;

endpackage

// File: rtl/debug_loader_unit_word_serializer.sv
// Splits an NB_DATA word into UART bytes, one tx_start pulse per byte,
// advancing only after tx_done. Byte order selected by BIG_ENDIAN.
module debug_loader_unit_word_serializer #(
  parameter int NB_DATA    = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               tx_done_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  output logic               done_o
);

  localparam int BPW   = NB_DATA / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [NB_DATA-1:0] word_r;
  logic [NB_DATA-1:0] shifted_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;

  function automatic logic [7:0] lead_byte(input logic [NB_DATA-1:0] w);
    if (BIG_ENDIAN) begin
      return w[NB_DATA-1 -: 8];
    end else begin
      return w[7:0];
    end
  endfunction

  // Next byte to present always sits at the leading end of the shifted word.
  always_comb begin
    shifted_s = word_r;
    if (BIG_ENDIAN) begin
      shifted_s = word_r << 4'd8;
    end else begin
      shifted_s = word_r >> 4'd8;
    end
  end

  // Byte sequencer: tx_data_o is held from tx_start_o until the matching tx_done_i.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      word_r     <= '0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      tx_data_o  <= 8'h00;
      tx_start_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      done_o     <= 1'b0;
      if (load_i) begin
        word_r     <= word_i;
        tx_data_o  <= lead_byte(word_i);
        tx_start_o <= 1'b1;
        cnt_r      <= '0;
        busy_r     <= 1'b1;
      end else if (busy_r && tx_done_i) begin
        if (cnt_r == CNT_W'(BPW - 1)) begin
          busy_r <= 1'b0;
          done_o <= 1'b1;
        end else begin
          word_r     <= shifted_s;
          tx_data_o  <= lead_byte(shifted_s);
          tx_start_o <= 1'b1;
          cnt_r      <= cnt_r + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_loader_unit.sv
// UART-side program loader and run/step debug controller for the MIPS pipeline:
// loads N words into imem, runs on command, then streams PC, cycle count and registers.
module debug_loader_unit
  import debug_loader_unit_pkg::*;
#(
  parameter int         NB_DATA       = 32,
  parameter int         ADDR_W        = ADDR_W_DEF,
  parameter int         N_REPORT_REGS = 32,
  parameter bit         BIG_ENDIAN    = 1'b0,
  parameter logic [7:0] CMD_STEP      = CMD_STEP_DEF,
  parameter logic [7:0] CMD_CONT      = CMD_CONT_DEF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [NB_DATA-1:0] imem_data_o,
  output logic               enable_pipe_o,
  input  logic               halt_i,
  input  logic [NB_DATA-1:0] pc_i,
  output logic [4:0]         reg_addr_o,
  input  logic [NB_DATA-1:0] reg_data_i,
  output logic               ack_debug_o,
  output logic               end_send_data_o
);

  localparam int BPW    = NB_DATA / 8;
  localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WIDX_W = $clog2(N_REPORT_REGS + 2);
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(N_REPORT_REGS + 1);

  dl_state_e          state_r, state_s;
  rpt_phase_e         phase_r;
  logic [BCNT_W-1:0]  byte_cnt_r;
  logic [7:0]         words_left_r;
  logic [ADDR_W-1:0]  wr_addr_r;
  logic [NB_DATA-1:0] asm_r, asm_next_s, rx_ext_s;
  logic [NB_DATA-1:0] cycle_cnt_r, pc_snap_r, rpt_word_s;
  logic [WIDX_W-1:0]  widx_r;
  logic [4:0]         reg_addr_r;
  logic               last_byte_s, ser_load_s, ser_done_s, ser_tx_done_s;

  function automatic logic [NB_DATA-1:0] sat_inc(input logic [NB_DATA-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + 1'b1;
    end
  endfunction

  assign imem_addr_o = wr_addr_r;
  assign imem_data_o = asm_r;
  assign reg_addr_o  = reg_addr_r;

  // Byte assembly: shifting in from the far end leaves byte 0 at the LSB (or MSB when big-endian).
  always_comb begin
    rx_ext_s    = NB_DATA'(rx_data_i);
    last_byte_s = (byte_cnt_r == BCNT_W'(BPW - 1));
    if (BIG_ENDIAN) begin
      asm_next_s = (asm_r << 4'd8) | rx_ext_s;
    end else begin
      asm_next_s = (asm_r >> 4'd8) | (rx_ext_s << (NB_DATA - 8));
    end
    if (widx_r == WIDX_W'(0)) begin
      rpt_word_s = pc_snap_r;
    end else if (widx_r == WIDX_W'(1)) begin
      rpt_word_s = cycle_cnt_r;
    end else begin
      rpt_word_s = reg_data_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and Moore-style output decode; enable is gated by halt_i combinationally.
  always_comb begin
    state_s         = state_r;
    imem_we_o       = 1'b0;
    ack_debug_o     = 1'b0;
    enable_pipe_o   = 1'b0;
    end_send_data_o = 1'b0;
    ser_load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid_i && (rx_data_i != 8'h00)) begin
          state_s = ST_RX_WORD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RX_WORD: begin
        if (rx_valid_i && last_byte_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_RX_WORD;
        end
      end
      ST_WRITE: begin
        imem_we_o = 1'b1;
        if (words_left_r == 8'd1) begin
          state_s = ST_WAIT_CMD;
        end else begin
          state_s = ST_RX_WORD;
        end
      end
      ST_WAIT_CMD: begin
        ack_debug_o = 1'b1;
        if (rx_valid_i && (rx_data_i == CMD_STEP)) begin
          state_s = ST_STEP;
        end else if (rx_valid_i && (rx_data_i == CMD_CONT)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_WAIT_CMD;
        end
      end
      ST_STEP: begin
        enable_pipe_o = 1'b1;
        state_s       = ST_REPORT;
      end
      ST_RUN: begin
        enable_pipe_o = ~halt_i;
        if (halt_i) begin
          state_s = ST_REPORT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_REPORT: begin
        ser_load_s = (phase_r == RP_LOAD);
        if ((phase_r == RP_BUSY) && ser_done_s && (widx_r == LAST_WIDX)) begin
          state_s = halt_i ? ST_DONE : ST_WAIT_CMD;
        end else begin
          state_s = ST_REPORT;
        end
      end
      ST_DONE: begin
        end_send_data_o = 1'b1;
        state_s         = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Load datapath: word count, byte counter, assembled word and write address.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      byte_cnt_r   <= '0;
      words_left_r <= 8'd0;
      wr_addr_r    <= '0;
      asm_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_valid_i && (rx_data_i != 8'h00)) begin
            words_left_r <= rx_data_i;
            wr_addr_r    <= '0;
            byte_cnt_r   <= '0;
          end
        end
        ST_RX_WORD: begin
          if (rx_valid_i) begin
            asm_r      <= asm_next_s;
            byte_cnt_r <= last_byte_s ? '0 : byte_cnt_r + 1'b1;
          end
        end
        ST_WRITE: begin
          words_left_r <= words_left_r - 8'd1;
          wr_addr_r    <= wr_addr_r + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Run/report datapath: saturating cycle count, PC snapshot and report word sequencing.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cycle_cnt_r <= '0;
      pc_snap_r   <= '0;
      widx_r      <= '0;
      phase_r     <= RP_ADDR;
      reg_addr_r  <= 5'd0;
    end else begin
      case (state_r)
        ST_STEP: begin
          cycle_cnt_r <= sat_inc(cycle_cnt_r);
          pc_snap_r   <= pc_i;
          widx_r      <= '0;
          phase_r     <= RP_ADDR;
        end
        ST_RUN: begin
          if (halt_i) begin
            pc_snap_r <= pc_i;
            widx_r    <= '0;
            phase_r   <= RP_ADDR;
          end else begin
            cycle_cnt_r <= sat_inc(cycle_cnt_r);
          end
        end
        ST_REPORT: begin
          case (phase_r)
            RP_ADDR: begin
              reg_addr_r <= (widx_r >= WIDX_W'(2)) ? 5'(widx_r - WIDX_W'(2)) : 5'd0;
              phase_r    <= RP_SETTLE;
            end
            RP_SETTLE: phase_r <= RP_LOAD;
            RP_LOAD:   phase_r <= RP_BUSY;
            RP_BUSY: begin
              if (ser_done_s) begin
                phase_r <= RP_ADDR;
                if (widx_r != LAST_WIDX) begin
                  widx_r <= widx_r + 1'b1;
                end
              end
            end
            default: phase_r <= RP_ADDR;
          endcase
        end
        ST_DONE: begin
          cycle_cnt_r <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign ser_tx_done_s = tx_done_i & (state_r == ST_REPORT);

  debug_loader_unit_word_serializer #(
    .NB_DATA    (NB_DATA),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_word_serializer (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (ser_load_s),
    .word_i     (rpt_word_s),
    .tx_done_i  (ser_tx_done_s),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .done_o     (ser_done_s)
  );

endmodule

// File: tb/tb_debug_loader_unit.sv
// Randomized self-checking bench: a 32-bit little-endian loader (a) and a
// 16-bit big-endian loader with 4 report registers (b), against a byte-level model.
module tb_debug_loader_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid_a, rx_valid_b, halt;
  logic [31:0] pc;

  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_start_a, tx_start_b, tx_done_a, tx_done_b;
  logic        imem_we_a, imem_we_b, en_a, en_b, ack_a, ack_b, end_a, end_b;
  logic [9:0]  imem_addr_a, imem_addr_b;
  logic [31:0] imem_data_a, reg_data_a;
  logic [15:0] imem_data_b, reg_data_b;
  logic [4:0]  reg_addr_a, reg_addr_b;

  logic [31:0] regs_a [32];
  logic [15:0] regs_b [32];
  logic [7:0]  txq_a[$], txq_b[$];
  logic [9:0]  wra_a[$], wra_b[$];
  logic [31:0] wrd_a[$], prog[$];
  logic [15:0] wrd_b[$];
  int en_cnt_a = 0, en_cnt_b = 0, end_cnt_a = 0, end_cnt_b = 0;
  int dly_a = 0, dly_b = 0;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  debug_loader_unit dut_a (
    .clock_i(clk), .reset_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid_a),
    .tx_data_o(tx_data_a), .tx_start_o(tx_start_a), .tx_done_i(tx_done_a),
    .imem_we_o(imem_we_a), .imem_addr_o(imem_addr_a), .imem_data_o(imem_data_a),
    .enable_pipe_o(en_a), .halt_i(halt), .pc_i(pc), .reg_addr_o(reg_addr_a),
    .reg_data_i(reg_data_a), .ack_debug_o(ack_a), .end_send_data_o(end_a));

  debug_loader_unit #(.NB_DATA(16), .N_REPORT_REGS(4), .BIG_ENDIAN(1'b1)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid_b),
    .tx_data_o(tx_data_b), .tx_start_o(tx_start_b), .tx_done_i(tx_done_b),
    .imem_we_o(imem_we_b), .imem_addr_o(imem_addr_b), .imem_data_o(imem_data_b),
    .enable_pipe_o(en_b), .halt_i(halt), .pc_i(pc[15:0]), .reg_addr_o(reg_addr_b),
    .reg_data_i(reg_data_b), .ack_debug_o(ack_b), .end_send_data_o(end_b));

  // Register file model with one cycle of read latency, and a UART TX with random byte time.
  always @(posedge clk) begin
    reg_data_a <= regs_a[reg_addr_a];
    reg_data_b <= regs_b[reg_addr_b];
    tx_done_a  <= 1'b0;
    tx_done_b  <= 1'b0;
    if (tx_start_a) dly_a <= $urandom_range(3, 1);
    else if (dly_a == 1) begin tx_done_a <= 1'b1; dly_a <= 0; end
    else if (dly_a > 1) dly_a <= dly_a - 1;
    if (tx_start_b) dly_b <= $urandom_range(3, 1);
    else if (dly_b == 1) begin tx_done_b <= 1'b1; dly_b <= 0; end
    else if (dly_b > 1) dly_b <= dly_b - 1;
  end

  // Output monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_start_a) txq_a.push_back(tx_data_a);
    if (tx_start_b) txq_b.push_back(tx_data_b);
    if (imem_we_a) begin wra_a.push_back(imem_addr_a); wrd_a.push_back(imem_data_a); end
    if (imem_we_b) begin wra_b.push_back(imem_addr_b); wrd_b.push_back(imem_data_b); end
    if (en_a) en_cnt_a <= en_cnt_a + 1;
    if (en_b) en_cnt_b <= en_cnt_b + 1;
    if (end_a) end_cnt_a <= end_cnt_a + 1;
    if (end_b) end_cnt_b <= end_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    if (sel) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends count byte then every word of prog in the instance's byte order, and checks the writes.
  task automatic load_and_check(input bit sel, input string tag);
    int n = prog.size();
    int bpw = sel ? 2 : 4;
    int sh;
    send(sel, 8'(n));
    foreach (prog[i]) begin
      for (int k = 0; k < bpw; k++) begin
        sh = sel ? 8 * (bpw - 1 - k) : 8 * k;
        send(sel, 8'(prog[i] >> sh));
      end
    end
    for (int i = 0; i < 200 && ((sel ? wrd_b.size() : wrd_a.size()) < n); i++) @(negedge clk);
    wait_cycles(5);
    chk({tag, "_wr_count"}, sel ? wrd_b.size() : wrd_a.size(), n);
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        chk({tag, "_wr_addr"}, (i < wra_b.size()) ? wra_b[i] : 10'h3FF, i % 1024);
        chk({tag, "_wr_data"}, (i < wrd_b.size()) ? {16'h0, wrd_b[i]} : 64'hDEAD, prog[i] & 32'hFFFF);
      end else begin
        chk({tag, "_wr_addr"}, (i < wra_a.size()) ? wra_a[i] : 10'h3FF, i % 1024);
        chk({tag, "_wr_data"}, (i < wrd_a.size()) ? wrd_a[i] : 64'hDEAD, prog[i]);
      end
    end
    chk({tag, "_ack"}, sel ? ack_b : ack_a, 1);
    wra_a.delete(); wrd_a.delete(); wra_b.delete(); wrd_b.delete();
  endtask

  // Collects a full report and compares it with PC, count and register words serialized by the model.
  task automatic check_report(input bit sel, input logic [31:0] pc_exp, input logic [31:0] cnt_exp);
    int bpw = sel ? 2 : 4;
    int nw = sel ? 6 : 34;
    int len = nw * bpw;
    int got_n, sh;
    logic [31:0] w;
    logic [63:0] g;
    for (int i = 0; i < 200 && ((sel ? txq_b.size() : txq_a.size()) == 0); i++) @(negedge clk);
    pc = $urandom;
    for (int i = 0; i < 20000 && ((sel ? txq_b.size() : txq_a.size()) < len); i++) @(negedge clk);
    wait_cycles(30);
    got_n = sel ? txq_b.size() : txq_a.size();
    chk("rpt_len", got_n, len);
    for (int wi = 0; wi < nw; wi++) begin
      if (wi == 0) w = pc_exp;
      else if (wi == 1) w = cnt_exp;
      else w = sel ? {16'h0, regs_b[wi - 2]} : regs_a[wi - 2];
      if (sel) w = w & 32'hFFFF;
      for (int k = 0; k < bpw; k++) begin
        sh = sel ? 8 * (bpw - 1 - k) : 8 * k;
        if (wi * bpw + k < got_n) g = sel ? txq_b[wi * bpw + k] : txq_a[wi * bpw + k];
        else g = 64'h100;
        chk($sformatf("rpt_w%0d_b%0d", wi, k), g, 8'(w >> sh));
      end
    end
    txq_a.delete();
    txq_b.delete();
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = $urandom;
      regs_b[i] = 16'($urandom);
    end
  endtask

  initial begin
    logic [31:0] pc0, cnt;
    int e0, d0;
    rx_data = 8'h00; rx_valid_a = 1'b0; rx_valid_b = 1'b0; halt = 1'b0; pc = 32'h0;
    rand_regs();
    rst_n = 1'b0;
    wait_cycles(3);
    chk("rst_a_ctl", {tx_start_a, imem_we_a, en_a, ack_a, end_a}, 0);
    chk("rst_a_bus", {reg_addr_a, imem_addr_a, tx_data_a}, 0);
    chk("rst_a_data", imem_data_a, 0);
    chk("rst_b_ctl", {tx_start_b, imem_we_b, en_b, ack_b, end_b, reg_addr_b, imem_addr_b, imem_data_b}, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Little-endian two-word load.
    prog = '{32'h12345678, 32'h87654321};
    load_and_check(1'b0, "t1");

    // Three single steps; a stray continue byte during the second report must be ignored.
    cnt = 0;
    for (int s = 0; s < 3; s++) begin
      rand_regs();
      pc = $urandom; pc0 = pc;
      e0 = en_cnt_a;
      send(1'b0, 8'h0F);
      if (s == 1) send(1'b0, 8'hF0);
      cnt++;
      check_report(1'b0, pc0, cnt);
      chk("t2_en_pulses", en_cnt_a - e0, 1);
      chk("t2_ack", ack_a, 1);
    end

    // Unknown command byte in WAIT_CMD.
    e0 = en_cnt_a;
    send(1'b0, 8'h55);
    wait_cycles(10);
    chk("t4_bad_cmd_en", en_cnt_a - e0, 0);
    chk("t4_bad_cmd_tx", txq_a.size(), 0);
    chk("t4_bad_cmd_ack", ack_a, 1);

    // Continuous run halted after exactly 20 enabled cycles.
    rand_regs();
    pc = $urandom; pc0 = pc;
    e0 = en_cnt_a; d0 = end_cnt_a;
    send(1'b0, 8'hF0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (en_cnt_a - e0 >= 20) begin halt = 1'b1; break; end
    end
    chk("t3_halt_raised", halt, 1);
    cnt += 20;
    check_report(1'b0, pc0, cnt);
    chk("t3_en_cycles", en_cnt_a - e0, 20);
    chk("t3_end_pulse", end_cnt_a - d0, 1);
    chk("t3_idle_ack", ack_a, 0);
    halt = 1'b0;

    // Zero count byte is ignored; then a random 0xAA-word program starting with byte 0F.
    send(1'b0, 8'h00);
    wait_cycles(10);
    chk("t4_zero_count_wr", wrd_a.size(), 0);
    chk("t4_zero_count_ack", ack_a, 0);
    prog.delete();
    for (int i = 0; i < 170; i++) prog.push_back($urandom);
    prog[0][7:0] = 8'h0F;
    load_and_check(1'b0, "t4_rand");

    // Run with halt already high: no enabled cycle, cleared count reported.
    halt = 1'b1;
    pc = $urandom; pc0 = pc;
    e0 = en_cnt_a; d0 = end_cnt_a;
    send(1'b0, 8'hF0);
    check_report(1'b0, pc0, 32'd0);
    chk("halted_run_en", en_cnt_a - e0, 0);
    chk("halted_run_end", end_cnt_a - d0, 1);
    halt = 1'b0;

    // Reset in the middle of a word; the partial word is never written.
    send(1'b0, 8'h01);
    send(1'b0, 8'hAB);
    send(1'b0, 8'hCD);
    #2 rst_n = 1'b0;
    #3;
    chk("t6_rst_ctl", {tx_start_a, imem_we_a, en_a, ack_a, end_a, reg_addr_a, imem_addr_a}, 0);
    chk("t6_rst_data", imem_data_a, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    chk("t6_no_partial_wr", wrd_a.size(), 0);
    prog = '{32'($urandom)};
    load_and_check(1'b0, "t6_reload");

    // Big-endian 16-bit instance.
    prog = '{32'h1234};
    load_and_check(1'b1, "t5");
    rand_regs();
    pc = $urandom; pc0 = pc & 32'hFFFF;
    e0 = en_cnt_b;
    send(1'b1, 8'h0F);
    check_report(1'b1, pc0, 32'd1);
    chk("t5_en_pulses", en_cnt_b - e0, 1);
    chk("t5_ack", ack_b, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
